// File: rtl/data_check.sv
// data_check: receive-side checker for the incrementing TTC test byte stream
module data_check #(
    parameter int LEN     = 220,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data,
    input  logic       clr,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic       overrun,
    output logic [8:0] byte_cnt,
    output logic [7:0] err_cnt,
    output logic [7:0] first_err_idx,
    output logic [7:0] first_err_data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state, state_n;
    logic [15:0] idle, idle_n;
    logic [8:0]  cnt_n;
    logic [7:0]  err_n, fidx_n, fdat_n;
    logic        to_n, ov_n, pass_n;

    // Next-state and result update; err_cnt==0 doubles as "no mismatch captured yet"
    always_comb begin
        state_n = state;
        idle_n  = idle;
        cnt_n   = byte_cnt;
        err_n   = err_cnt;
        fidx_n  = first_err_idx;
        fdat_n  = first_err_data;
        to_n    = timeout;
        ov_n    = overrun;
        if (clr) begin
            state_n = IDLE;
            idle_n  = '0;
            cnt_n   = '0;
            err_n   = '0;
            fidx_n  = '0;
            fdat_n  = '0;
            to_n    = 1'b0;
            ov_n    = 1'b0;
        end else if (state == DONE) begin
            ov_n = overrun | en;
        end else if (en) begin
            idle_n = '0;
            cnt_n  = byte_cnt + 9'd1;
            if (data != byte_cnt[7:0]) begin
                err_n  = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
                fidx_n = (err_cnt == 8'd0) ? byte_cnt[7:0] : first_err_idx;
                fdat_n = (err_cnt == 8'd0) ? data : first_err_data;
            end
            state_n = (cnt_n == 9'(LEN)) ? DONE : RUN;
        end else if (state == RUN) begin
            idle_n  = idle + 16'd1;
            to_n    = (idle_n == 16'(TIMEOUT));
            state_n = to_n ? DONE : RUN;
        end
        pass_n = (state_n == DONE) && (cnt_n == 9'(LEN)) && (err_n == 8'd0) && !to_n && !ov_n;
    end

    // State and result registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idle           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            overrun        <= 1'b0;
            byte_cnt       <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
        end else begin
            state          <= state_n;
            idle           <= idle_n;
            busy           <= (state_n == RUN);
            done           <= (state_n == DONE);
            pass           <= pass_n;
            timeout        <= to_n;
            overrun        <= ov_n;
            byte_cnt       <= cnt_n;
            err_cnt        <= err_n;
            first_err_idx  <= fidx_n;
            first_err_data <= fdat_n;
        end
    end
endmodule

// File: tb/tb_data_check.sv
// tb_data_check: directed table-driven bench for data_check
module tb_data_check;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
    logic [7:0] data = '0;
    logic       busy, done, pass, timeout, overrun;
    logic [8:0] byte_cnt;
    logic [7:0] err_cnt, first_err_idx, first_err_data;

    logic       en2 = 1'b0, clr2 = 1'b0;
    logic [7:0] data2 = '0;
    logic       busy2, done2, pass2, timeout2, overrun2;
    logic [8:0] byte_cnt2;
    logic [7:0] err_cnt2, first_err_idx2, first_err_data2;

    int n_chk = 0, n_fail = 0;

    data_check u_dut (
        .clk(clk), .rst(rst), .en(en), .data(data), .clr(clr),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .overrun(overrun),
        .byte_cnt(byte_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data)
    );

    data_check #(.LEN(256)) u_sat (
        .clk(clk), .rst(rst), .en(en2), .data(data2), .clr(clr2),
        .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2), .overrun(overrun2),
        .byte_cnt(byte_cnt2), .err_cnt(err_cnt2),
        .first_err_idx(first_err_idx2), .first_err_data(first_err_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ia;
        logic [7:0] va;
        int         ib;
        logic [7:0] vb;
        int         err;
        int         fidx;
        int         fdat;
        int         pass;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int b, input int d, input int p, input int t,
                           input int o, input int c, input int e, input int fi, input int fd);
        chk({name, ".busy"}, busy, b);
        chk({name, ".done"}, done, d);
        chk({name, ".pass"}, pass, p);
        chk({name, ".timeout"}, timeout, t);
        chk({name, ".overrun"}, overrun, o);
        chk({name, ".byte_cnt"}, byte_cnt, c);
        chk({name, ".err_cnt"}, err_cnt, e);
        chk({name, ".first_err_idx"}, first_err_idx, fi);
        chk({name, ".first_err_data"}, first_err_data, fd);
    endtask

    task automatic beat(input logic [7:0] d);
        en = 1'b1;
        data = d;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic gap(input int g);
        en = 1'b0;
        repeat (g) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic run(input int n, input int ia, input logic [7:0] va, input int ib,
                       input logic [7:0] vb, input int maxgap);
        for (int i = 0; i < n; i++) begin
            beat(i == ia ? va : i == ib ? vb : 8'(i));
            if (i == 0) chk("run.busy_after_first", busy, 1);
            if (maxgap > 0 && i < n - 1)
                gap((i == 10 || i == 150) ? 1022 : $urandom_range(0, maxgap));
        end
    endtask

    initial begin
        int cyc;
        tbl[0] = '{-1, 8'h00, -1, 8'h00, 0, 0, 0, 1};
        tbl[1] = '{5, 8'hFF, 200, 8'h00, 2, 5, 255, 0};
        tbl[2] = '{0, 8'h80, -1, 8'h00, 1, 0, 128, 0};
        tbl[3] = '{219, 8'h00, -1, 8'h00, 1, 219, 0, 0};
        tbl[4] = '{7, 8'h07, -1, 8'h00, 0, 0, 0, 1};
        tbl[5] = '{100, 8'h65, 101, 8'h64, 2, 100, 101, 0};

        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            clear();
            run(220, tbl[k].ia, tbl[k].va, tbl[k].ib, tbl[k].vb, 0);
            chk_all($sformatf("vec%0d", k), 0, 1, tbl[k].pass, 0, 0, 220,
                    tbl[k].err, tbl[k].fidx, tbl[k].fdat);
        end

        clear();
        run(220, -1, 8'h00, -1, 8'h00, 20);
        chk_all("gapped", 0, 1, 1, 0, 0, 220, 0, 0, 0);

        clear();
        run(100, -1, 8'h00, -1, 8'h00, 0);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("timeout.cycles", cyc, 1024);
        chk_all("timeout", 0, 1, 0, 1, 0, 100, 0, 0, 0);

        clear();
        run(220, -1, 8'h00, -1, 8'h00, 0);
        chk("overrun.pass_before", pass, 1);
        for (int i = 0; i < 3; i++) beat(8'(220 + i));
        chk_all("overrun", 0, 1, 0, 0, 1, 220, 0, 0, 0);

        clear();
        chk_all("clr", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(50, 3, 8'hAA, -1, 8'h00, 0);
        en = 1'b1;
        data = 8'd50;
        clr = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        clr = 1'b0;
        chk_all("clr_with_en", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        gap(2);
        chk_all("clr_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(220, -1, 8'h00, -1, 8'h00, 0);
        chk_all("after_clr", 0, 1, 1, 0, 0, 220, 0, 0, 0);

        clear();
        run(120, 60, 8'h00, -1, 8'h00, 0);
        en = 1'b1;
        data = 8'd120;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("rst_release", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(220, -1, 8'h00, -1, 8'h00, 0);
        chk_all("after_rst", 0, 1, 1, 0, 0, 220, 0, 0, 0);

        for (int i = 0; i < 256; i++) begin
            en2 = 1'b1;
            data2 = ~8'(i);
            @(posedge clk);
            #1;
        end
        en2 = 1'b0;
        chk("sat.done", done2, 1);
        chk("sat.pass", pass2, 0);
        chk("sat.busy", busy2, 0);
        chk("sat.byte_cnt", byte_cnt2, 256);
        chk("sat.err_cnt", err_cnt2, 255);
        chk("sat.first_err_idx", first_err_idx2, 0);
        chk("sat.first_err_data", first_err_data2, 255);
        chk("sat.timeout", timeout2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
